// File: rtl/alu_pkg.sv
// Shared ALU op encodings and arbiter FSM state type.
package alu_pkg;

    localparam logic [2:0] ALU_OP_ADD = 3'b000;
    localparam logic [2:0] ALU_OP_SUB = 3'b001;
    localparam logic [2:0] ALU_OP_AND = 3'b010;
    localparam logic [2:0] ALU_OP_OR  = 3'b011;
    localparam logic [2:0] ALU_OP_SLT = 3'b100;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } arb_state_e;

endpackage

// File: rtl/alu_arbiter_rr.sv
// Combinational round-robin grant: first requester above ptr, wrapping.
module rr_arbiter #(
    parameter int N_REQ = 2,
    parameter int ID_W  = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [ID_W-1:0]  ptr,
    output logic [N_REQ-1:0] gnt,
    output logic [ID_W-1:0]  gnt_idx,
    output logic             gnt_valid
);

    int idx;

    always_comb begin
        gnt       = '0;
        gnt_idx   = '0;
        gnt_valid = 1'b0;
        idx       = 0;
        for (int k = 1; k <= N_REQ; k++) begin
            idx = (int'(ptr) + k) % N_REQ;
            if (!gnt_valid && req[idx]) begin
                gnt_valid = 1'b1;
                gnt_idx   = ID_W'(idx);
                gnt[idx]  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/alu_arbiter.sv
// Round-robin sharing of one external combinational ALU among N_REQ requesters.
//   state | meaning
//   IDLE  | arbitrate, accept one request and register its operands
//   EXEC  | ALU settles, capture result/zero/owner
//   RESP  | hold response until owner asserts rsp_ready
module alu_arbiter
    import alu_pkg::*;
#(
    parameter int N_REQ = 2,
    parameter int WIDTH = 32,
    localparam int ID_W = $clog2(N_REQ)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [N_REQ-1:0]   req_valid,
    output logic [N_REQ-1:0]   req_ready,
    input  logic [N_REQ*WIDTH-1:0] req_a,
    input  logic [N_REQ*WIDTH-1:0] req_b,
    input  logic [N_REQ*3-1:0] req_op,
    output logic               rsp_valid,
    input  logic [N_REQ-1:0]   rsp_ready,
    output logic [ID_W-1:0]    rsp_id,
    output logic [WIDTH-1:0]   rsp_result,
    output logic               rsp_zero,
    output logic [WIDTH-1:0]   alu_a,
    output logic [WIDTH-1:0]   alu_b,
    output logic [2:0]         alu_op,
    input  logic [WIDTH-1:0]   alu_result,
    input  logic               alu_zero,
    output logic               busy
);

    arb_state_e       state_q, state_d;
    logic [ID_W-1:0]  ptr_q, ptr_d;
    logic [ID_W-1:0]  owner_q, owner_d;
    logic [WIDTH-1:0] alu_a_q, alu_a_d;
    logic [WIDTH-1:0] alu_b_q, alu_b_d;
    logic [2:0]       alu_op_q, alu_op_d;
    logic [WIDTH-1:0] rsp_result_q, rsp_result_d;
    logic             rsp_zero_q, rsp_zero_d;
    logic [ID_W-1:0]  rsp_id_q, rsp_id_d;
    logic             rsp_valid_q, rsp_valid_d;

    logic [N_REQ-1:0] gnt;
    logic [ID_W-1:0]  gnt_idx;
    logic             gnt_valid;

    rr_arbiter #(.N_REQ(N_REQ), .ID_W(ID_W)) u_rr (
        .req       (req_valid),
        .ptr       (ptr_q),
        .gnt       (gnt),
        .gnt_idx   (gnt_idx),
        .gnt_valid (gnt_valid)
    );

    always_comb begin
        state_d      = state_q;
        ptr_d        = ptr_q;
        owner_d      = owner_q;
        alu_a_d      = alu_a_q;
        alu_b_d      = alu_b_q;
        alu_op_d     = alu_op_q;
        rsp_result_d = rsp_result_q;
        rsp_zero_d   = rsp_zero_q;
        rsp_id_d     = rsp_id_q;
        rsp_valid_d  = rsp_valid_q;
        req_ready    = '0;
        case (state_q)
            IDLE: begin
                req_ready = gnt;
                if (gnt_valid) begin
                    alu_a_d  = req_a[int'(gnt_idx)*WIDTH +: WIDTH];
                    alu_b_d  = req_b[int'(gnt_idx)*WIDTH +: WIDTH];
                    alu_op_d = req_op[int'(gnt_idx)*3 +: 3];
                    owner_d  = gnt_idx;
                    ptr_d    = gnt_idx;
                    state_d  = EXEC;
                end
            end
            EXEC: begin
                rsp_result_d = alu_result;
                rsp_zero_d   = alu_zero;
                rsp_id_d     = owner_q;
                rsp_valid_d  = 1'b1;
                state_d      = RESP;
            end
            RESP: begin
                // Only the owner's ready bit can retire the response.
                if (rsp_ready[rsp_id_q]) begin
                    rsp_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            ptr_q        <= ID_W'(N_REQ - 1);
            owner_q      <= '0;
            alu_a_q      <= '0;
            alu_b_q      <= '0;
            alu_op_q     <= '0;
            rsp_result_q <= '0;
            rsp_zero_q   <= 1'b0;
            rsp_id_q     <= '0;
            rsp_valid_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            ptr_q        <= ptr_d;
            owner_q      <= owner_d;
            alu_a_q      <= alu_a_d;
            alu_b_q      <= alu_b_d;
            alu_op_q     <= alu_op_d;
            rsp_result_q <= rsp_result_d;
            rsp_zero_q   <= rsp_zero_d;
            rsp_id_q     <= rsp_id_d;
            rsp_valid_q  <= rsp_valid_d;
        end
    end

    assign alu_a      = alu_a_q;
    assign alu_b      = alu_b_q;
    assign alu_op     = alu_op_q;
    assign rsp_result = rsp_result_q;
    assign rsp_zero   = rsp_zero_q;
    assign rsp_id     = rsp_id_q;
    assign rsp_valid  = rsp_valid_q;
    assign busy       = (state_q != IDLE);

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter with a behavioural ALU attached.
module tb_alu_arbiter;
    import alu_pkg::*;

    localparam int N = 2;
    localparam int W = 32;

    logic           clk = 1'b0;
    logic           rst;
    logic [N-1:0]   req_valid;
    logic [N-1:0]   req_ready;
    logic [N*W-1:0] req_a;
    logic [N*W-1:0] req_b;
    logic [N*3-1:0] req_op;
    logic           rsp_valid;
    logic [N-1:0]   rsp_ready;
    logic [0:0]     rsp_id;
    logic [W-1:0]   rsp_result;
    logic           rsp_zero;
    logic [W-1:0]   alu_a;
    logic [W-1:0]   alu_b;
    logic [2:0]     alu_op;
    logic [W-1:0]   alu_result;
    logic           alu_zero;
    logic           busy;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    alu_arbiter #(.N_REQ(N), .WIDTH(W)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_a(req_a), .req_b(req_b), .req_op(req_op),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
        .rsp_result(rsp_result), .rsp_zero(rsp_zero),
        .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
        .alu_result(alu_result), .alu_zero(alu_zero),
        .busy(busy)
    );

    always_comb begin
        case (alu_op)
            ALU_OP_ADD: alu_result = alu_a + alu_b;
            ALU_OP_SUB: alu_result = alu_a - alu_b;
            ALU_OP_AND: alu_result = alu_a & alu_b;
            ALU_OP_OR:  alu_result = alu_a | alu_b;
            ALU_OP_SLT: alu_result = ($signed(alu_a) < $signed(alu_b)) ? 32'd1 : 32'd0;
            default:    alu_result = 32'd0;
        endcase
        alu_zero = (alu_result == 32'd0);
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    // One full transaction from requester id with no competition; starts and ends at a negedge in IDLE.
    task automatic run_op(input int id, input logic [31:0] a, input logic [31:0] b,
                          input logic [2:0] op, input logic [31:0] exp_res, input logic exp_zero);
        req_a[id*W +: W] = a;
        req_b[id*W +: W] = b;
        req_op[id*3 +: 3] = op;
        req_valid = '0;
        req_valid[id] = 1'b1;
        #1 chk("op_ready", 32'(req_ready), 32'(1 << id));
        @(negedge clk);
        req_valid = '0;
        chk("op_alu_a", alu_a, a);
        chk("op_alu_b", alu_b, b);
        chk("op_exec_busy", 32'(busy), 32'd1);
        chk("op_exec_nrdy", 32'(req_ready), 32'd0);
        chk("op_exec_nvld", 32'(rsp_valid), 32'd0);
        @(negedge clk);
        chk("op_rsp_valid", 32'(rsp_valid), 32'd1);
        chk("op_rsp_result", rsp_result, exp_res);
        chk("op_rsp_zero", 32'(rsp_zero), 32'(exp_zero));
        chk("op_rsp_id", 32'(rsp_id), 32'(id));
        rsp_ready = '0;
        rsp_ready[id] = 1'b1;
        @(negedge clk);
        rsp_ready = '0;
        chk("op_done_vld", 32'(rsp_valid), 32'd0);
        chk("op_done_busy", 32'(busy), 32'd0);
    endtask

    initial begin
        int last_cyc;
        int last_gnt;
        int g_cnt;

        rst = 1'b1;
        req_valid = '0;
        req_a = '0;
        req_b = '0;
        req_op = '0;
        rsp_ready = '0;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        chk("rst_valid", 32'(rsp_valid), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_alu_a", alu_a, 32'd0);
        chk("rst_result", rsp_result, 32'd0);
        chk("rst_ready", 32'(req_ready), 32'd0);

        run_op(0, 32'd7, 32'd5, ALU_OP_SUB, 32'd2, 1'b0);
        run_op(1, 32'hFFFF_FFFF, 32'd1, ALU_OP_SLT, 32'd1, 1'b0);
        run_op(0, 32'd5, 32'd5, ALU_OP_SUB, 32'd0, 1'b1);
        run_op(1, 32'd3, 32'd4, 3'b111, 32'd0, 1'b1);

        // Round robin from a fresh pointer: grants 0,1,0,1 three cycles apart.
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        req_a = {32'h0000_00F0, 32'd10};
        req_b = {32'h0000_000F, 32'd1};
        req_op = {ALU_OP_OR, ALU_OP_ADD};
        req_valid = 2'b11;
        rsp_ready = 2'b11;
        last_cyc = -1;
        last_gnt = 1;
        g_cnt = 0;
        for (int c = 0; c < 12; c++) begin
            #1;
            if (req_ready != 2'b00) begin
                chk("rr_gnt", 32'(req_ready), (last_gnt == 1) ? 32'd1 : 32'd2);
                if (last_cyc >= 0) chk("rr_gap", 32'(c - last_cyc), 32'd3);
                last_cyc = c;
                last_gnt = 1 - last_gnt;
                g_cnt++;
            end
            if (rsp_valid) begin
                chk("rr_id", 32'(rsp_id), 32'(last_gnt));
                chk("rr_res", rsp_result, (last_gnt == 1) ? 32'h0000_00FF : 32'd11);
            end
            @(negedge clk);
        end
        chk("rr_count", 32'(g_cnt), 32'd4);
        req_valid = '0;
        rsp_ready = '0;
        @(negedge clk);

        // Backpressure on requester 1; requester 0 waits and the non-owner ready bit is ignored.
        req_a[W +: W] = 32'h0000_FF00;
        req_b[W +: W] = 32'h0000_0FF0;
        req_op[3 +: 3] = ALU_OP_AND;
        req_valid = 2'b10;
        #1 chk("bp_gnt", 32'(req_ready), 32'd2);
        @(negedge clk);
        req_valid = 2'b01;
        req_a[0 +: W] = 32'd1;
        req_b[0 +: W] = 32'd2;
        req_op[0 +: 3] = ALU_OP_ADD;
        @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            #1;
            chk("bp_valid", 32'(rsp_valid), 32'd1);
            chk("bp_result", rsp_result, 32'h0000_0F00);
            chk("bp_zero", 32'(rsp_zero), 32'd0);
            chk("bp_id", 32'(rsp_id), 32'd1);
            chk("bp_nrdy", 32'(req_ready), 32'd0);
            chk("bp_busy", 32'(busy), 32'd1);
            rsp_ready = 2'b01;
            @(negedge clk);
        end
        rsp_ready = 2'b10;
        @(negedge clk);
        rsp_ready = 2'b00;
        #1;
        chk("bp_release", 32'(rsp_valid), 32'd0);
        chk("bp_next_gnt", 32'(req_ready), 32'd1);

        // Reset during EXEC discards the operation and restores priority to requester 0.
        @(negedge clk);
        chk("mid_alu_a", alu_a, 32'd1);
        chk("mid_busy", 32'(busy), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        chk("mid_rst_busy", 32'(busy), 32'd0);
        chk("mid_rst_valid", 32'(rsp_valid), 32'd0);
        chk("mid_rst_alu_a", alu_a, 32'd0);
        chk("mid_rst_alu_b", alu_b, 32'd0);
        chk("mid_rst_alu_op", 32'(alu_op), 32'd0);
        chk("mid_rst_result", rsp_result, 32'd0);
        chk("mid_rst_id", 32'(rsp_id), 32'd0);
        chk("mid_rst_zero", 32'(rsp_zero), 32'd0);
        rst = 1'b0;
        req_valid = 2'b11;
        #1 chk("mid_rst_gnt", 32'(req_ready), 32'd1);
        @(negedge clk);
        chk("mid_rst_norsp", 32'(rsp_valid), 32'd0);
        req_valid = '0;
        @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/alu_arbiter.md
Name: alu_arbiter

Overview:
- Shares one combinational ALU (ADD/SUB/AND/OR/SLT, 3-bit op, 32-bit operands, Zero flag) between N_REQ requesters, e.g. the integer pipeline and the address/branch unit.
- Uses round-robin arbitration with a valid/ready request handshake per requester.
- Registers the operands into the ALU, captures the result and Zero flag, and returns them on a held response channel tagged with the requester id.
- Sits between the requesters and the ALU instance, which it drives exclusively.

Parameters:
- N_REQ, 2, number of requesters; legal range 2..8.
- WIDTH, 32, operand/result width; must equal the ALU width.
- ID_W, $clog2(N_REQ), width of the requester id (derived, not overridden).

Ports:
- clk  in  1  system clock; one clock domain.
- rst  in  1  reset; synchronous, active-high.
- req_valid  in  N_REQ  per-requester request valid.
- req_ready  out  N_REQ  per-requester accept; one-hot or zero.
- req_a  in  N_REQ*WIDTH  operand A, requester i in slice [i*WIDTH +: WIDTH].
- req_b  in  N_REQ*WIDTH  operand B, same packing.
- req_op  in  N_REQ*3  ALU op, requester i in slice [i*3 +: 3].
- rsp_valid  out  1  response valid.
- rsp_ready  in  N_REQ  per-requester response accept.
- rsp_id  out  ID_W  requester that owns the response.
- rsp_result  out  WIDTH  captured ALU result.
- rsp_zero  out  1  captured ALU Zero flag.
- alu_a  out  WIDTH  registered operand A to ALU.
- alu_b  out  WIDTH  registered operand B to ALU.
- alu_op  out  3  registered op to ALU.
- alu_result  in  WIDTH  ALU result (combinational from alu_a/alu_b/alu_op).
- alu_zero  in  1  ALU Zero flag.
- busy  out  1  high whenever state != IDLE.

Behaviour:
- Reset (rst high at a clk edge): state=IDLE; alu_a/alu_b/alu_op/rsp_result/rsp_id=0; rsp_zero=0; rsp_valid=0; rr pointer=N_REQ-1, so requester 0 has first priority. Reset overrides every state, including mid-EXEC/RESP; an in-flight result is discarded and no response is issued.
- FSM IDLE -> EXEC -> RESP -> IDLE.
- IDLE:
  - Grant = first i with req_valid[i], searching from (ptr+1) mod N_REQ upward with wrap.
  - req_ready[grant]=1 combinationally; all other req_ready bits are 0.
  - No valid requests -> req_ready=0, stay in IDLE.
  - On acceptance (cycle T): register req_a/b/op of the grant into alu_a/b/op, record the grant as owner, set ptr=grant, go to EXEC.
- EXEC (cycle T+1): ALU settles combinationally; at the end of the cycle capture alu_result->rsp_result, alu_zero->rsp_zero and owner->rsp_id; set rsp_valid=1; go to RESP.
- RESP (T+2 onward): rsp_valid=1 and rsp_result/rsp_zero/rsp_id held stable. Only rsp_ready[rsp_id] matters; other bits are ignored. On rsp_ready[rsp_id]=1: rsp_valid=0 next cycle, go to IDLE.
- req_ready=0 in EXEC and RESP; there is no acceptance in the same cycle as response completion.
- Latency: accept at T, rsp_valid at T+2. Max throughput is 1 operation per 3 cycles.
- alu_a/alu_b/alu_op hold their last values outside EXEC; they are not cleared.
- Op codes are passed through unchecked. Undefined codes 101..111 yield result 0, zero=1 from the ALU, returned normally.
- Arithmetic is done entirely by the ALU; the block never modifies data.
- Fairness: a continuously-valid requester waits at most N_REQ-1 other grants.
- A requester may drop req_valid without being granted; no state is kept for it.

Decomposition:
- Shared package alu_pkg holds:
  - ALU op constants ALU_OP_ADD=000, SUB=001, AND=010, OR=011, SLT=100, also used by the ALU and the control unit.
  - The FSM state enum {IDLE, EXEC, RESP}.
- One sub-module rr_arbiter: combinational grant from req vector and pointer, producing a one-hot grant plus an index. Pointer update stays in alu_arbiter.

Test Plan:
- Single request: req 0 sends A=7, B=5, op SUB at T -> req_ready[0]=1 at T; alu_a=7 at T+1; rsp_valid at T+2 with rsp_result=2, rsp_zero=0, rsp_id=0.
- Zero flag and SLT: A=0xFFFFFFFF (-1), B=1, op SLT -> rsp_result=1, zero=0. Then A=5, B=5, op SUB -> result=0, zero=1.
- Round-robin: both requesters hold valid permanently, rsp_ready always 1 -> grants alternate 0,1,0,1, each accepted 3 cycles apart.
- Response backpressure: rsp_ready[rsp_id]=0 for 4 cycles -> rsp_valid and rsp_result stable, req_ready=0, busy=1. Asserting rsp_ready[1-rsp_id] alone has no effect.
- Reset mid-operation: assert rst during EXEC -> next cycle state=IDLE, rsp_valid=0, all outputs 0, and the next grant goes to requester 0.
- Undefined op 111 with A=3, B=4 -> rsp_result=0, rsp_zero=1, handshake completes normally.
